punc_control_fsm: RTL

//  Multicycle control FSM for the PUnC LC3 datapath. Fetches, decodes and sequences

---
 rtl/punc_control_fsm_pkg.sv | 71 +++++++
 rtl/punc_control_fsm_if.sv | 34 +++
 rtl/punc_decode.sv | 94 +++++++++
 rtl/punc_control_fsm.sv | 77 +++++++
 4 files changed

// File: rtl/punc_control_fsm_pkg.sv
// Shared encodings for the PUnC control FSM and datapath: opcodes, FSM states,
// mux selects, ALU ops and the bundled control word.
package punc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] PC_INC   = 2'd0;
  localparam logic [1:0] PC_OFF9  = 2'd1;
  localparam logic [1:0] PC_OFF11 = 2'd2;
  localparam logic [1:0] PC_BASER = 2'd3;

  localparam logic [1:0] MEM_PC   = 2'd0;
  localparam logic [1:0] MEM_OFF9 = 2'd1;
  localparam logic [1:0] MEM_OFF6 = 2'd2;
  localparam logic [1:0] MEM_TEMP = 2'd3;

  localparam logic [1:0] RFD_ALU = 2'd0;
  localparam logic [1:0] RFD_MEM = 2'd1;
  localparam logic [1:0] RFD_PC  = 2'd2;
  localparam logic [1:0] RFD_LEA = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_AND  = 2'd1;
  localparam logic [1:0] ALU_NOT  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_ld;
    logic [1:0] pc_sel;
    logic [1:0] mem_r_sel;
    logic       mem_w_en;
    logic       temp_ld;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r_addr_sel;
    logic [1:0] alu_op;
    logic       cc_ld;
    logic       halted;
  } ctrl_t;

  function automatic logic br_taken(input logic [2:0] nzp_mask, input logic n,
                                    input logic z, input logic p);
    return |(nzp_mask & {n, z, p});
  endfunction

endpackage

// File: rtl/punc_control_fsm_if.sv
// Control/status bundle between the PUnC control FSM (master) and datapath (slave).
interface punc_control_fsm_if;
  import punc_control_fsm_pkg::*;

  logic [15:0] ir;
  logic        cc_n;
  logic        cc_z;
  logic        cc_p;
  logic        ir_ld;
  logic        pc_ld;
  logic [1:0]  pc_sel;
  logic [1:0]  mem_r_sel;
  logic        mem_w_en;
  logic        temp_ld;
  logic        rf_w_en;
  logic        rf_w_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_r_addr_sel;
  logic [1:0]  alu_op;
  logic        cc_ld;
  logic        halted;

  modport master (
    input  ir, cc_n, cc_z, cc_p,
    output ir_ld, pc_ld, pc_sel, mem_r_sel, mem_w_en, temp_ld, rf_w_en,
           rf_w_addr_sel, rf_w_data_sel, rf_r_addr_sel, alu_op, cc_ld, halted
  );

  modport slave (
    output ir, cc_n, cc_z, cc_p,
    input  ir_ld, pc_ld, pc_sel, mem_r_sel, mem_w_en, temp_ld, rf_w_en,
           rf_w_addr_sel, rf_w_data_sel, rf_r_addr_sel, alu_op, cc_ld, halted
  );
endinterface

// File: rtl/punc_decode.sv
// Combinational control-word decode from FSM state, opcode and condition codes.
// Reset forces the whole word to zero so nothing fires while rst is held.
module punc_decode
  import punc_control_fsm_pkg::*;
(
  input  logic       rst_i,
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic [2:0] nzp_i,
  input  logic       cc_n_i,
  input  logic       cc_z_i,
  input  logic       cc_p_i,
  output ctrl_t      ctrl_o
);

  // control word for the current state and instruction
  always_comb begin
    ctrl_o = '0;
    if (rst_i) begin
      ctrl_o = '0;
    end else begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.ir_ld = 1'b1;
          ctrl_o.pc_ld = 1'b1;
        end
        S_DECODE: ctrl_o = '0;
        S_EXEC: begin
          case (op_i)
            OP_ADD, OP_AND, OP_NOT: begin
              ctrl_o.rf_w_en       = 1'b1;
              ctrl_o.rf_w_data_sel = RFD_ALU;
              ctrl_o.cc_ld         = 1'b1;
              ctrl_o.alu_op        = (op_i == OP_ADD) ? ALU_ADD :
                                     (op_i == OP_AND) ? ALU_AND : ALU_NOT;
            end
            OP_BR: begin
              ctrl_o.pc_ld  = br_taken(nzp_i, cc_n_i, cc_z_i, cc_p_i);
              ctrl_o.pc_sel = PC_OFF9;
            end
            OP_JMP: begin
              ctrl_o.pc_ld  = 1'b1;
              ctrl_o.pc_sel = PC_BASER;
            end
            // R7 link and the jump share one edge, so JSRR R7 still sees the old R7
            OP_JSR: begin
              ctrl_o.rf_w_en       = 1'b1;
              ctrl_o.rf_w_addr_sel = 1'b1;
              ctrl_o.rf_w_data_sel = RFD_PC;
              ctrl_o.pc_ld         = 1'b1;
              ctrl_o.pc_sel        = nzp_i[2] ? PC_OFF11 : PC_BASER;
            end
            OP_LD, OP_LDR: begin
              ctrl_o.rf_w_en       = 1'b1;
              ctrl_o.rf_w_data_sel = RFD_MEM;
              ctrl_o.mem_r_sel     = (op_i == OP_LD) ? MEM_OFF9 : MEM_OFF6;
              ctrl_o.cc_ld         = 1'b1;
            end
            OP_LEA: begin
              ctrl_o.rf_w_en       = 1'b1;
              ctrl_o.rf_w_data_sel = RFD_LEA;
            end
            OP_ST, OP_STR: begin
              ctrl_o.mem_w_en      = 1'b1;
              ctrl_o.mem_r_sel     = (op_i == OP_ST) ? MEM_OFF9 : MEM_OFF6;
              ctrl_o.rf_r_addr_sel = 1'b1;
            end
            OP_LDI, OP_STI: begin
              ctrl_o.temp_ld   = 1'b1;
              ctrl_o.mem_r_sel = MEM_OFF9;
            end
            default: ctrl_o = '0;
          endcase
        end
        S_EXEC2: begin
          ctrl_o.mem_r_sel = MEM_TEMP;
          if (op_i == OP_LDI) begin
            ctrl_o.rf_w_en       = 1'b1;
            ctrl_o.rf_w_data_sel = RFD_MEM;
            ctrl_o.cc_ld         = 1'b1;
          end else if (op_i == OP_STI) begin
            ctrl_o.mem_w_en      = 1'b1;
            ctrl_o.rf_r_addr_sel = 1'b1;
          end else begin
            ctrl_o.mem_w_en = 1'b0;
          end
        end
        S_HALT:  ctrl_o.halted = 1'b1;
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/punc_control_fsm.sv
// PUnC LC3 multicycle control FSM: state register plus next-state logic;
// the control word itself comes from punc_decode.
module punc_control_fsm
  import punc_control_fsm_pkg::*;
#(
  parameter logic [7:0] TRAP_HALT_VECT = 8'h25,
  parameter bit         ILLEGAL_HALTS  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  punc_control_fsm_if.master  ctrl
);

  state_e      state_q;
  state_e      state_d;
  ctrl_t       word_s;
  logic [3:0]  op_s;
  logic        unused_ir8_s;

  assign op_s         = ctrl.ir[15:12];
  assign unused_ir8_s = ctrl.ir[8];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_s == OP_LDI || op_s == OP_STI) begin
          state_d = S_EXEC2;
        end else if (op_s == OP_TRAP && ctrl.ir[7:0] == TRAP_HALT_VECT) begin
          state_d = S_HALT;
        end else if ((op_s == OP_RTI || op_s == OP_RES) && ILLEGAL_HALTS) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC2:  state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  punc_decode u_decode (
    .rst_i   (rst),
    .state_i (state_q),
    .op_i    (op_s),
    .nzp_i   (ctrl.ir[11:9]),
    .cc_n_i  (ctrl.cc_n),
    .cc_z_i  (ctrl.cc_z),
    .cc_p_i  (ctrl.cc_p),
    .ctrl_o  (word_s)
  );

  assign ctrl.ir_ld         = word_s.ir_ld;
  assign ctrl.pc_ld         = word_s.pc_ld;
  assign ctrl.pc_sel        = word_s.pc_sel;
  assign ctrl.mem_r_sel     = word_s.mem_r_sel;
  assign ctrl.mem_w_en      = word_s.mem_w_en;
  assign ctrl.temp_ld       = word_s.temp_ld;
  assign ctrl.rf_w_en       = word_s.rf_w_en;
  assign ctrl.rf_w_addr_sel = word_s.rf_w_addr_sel;
  assign ctrl.rf_w_data_sel = word_s.rf_w_data_sel;
  assign ctrl.rf_r_addr_sel = word_s.rf_r_addr_sel;
  assign ctrl.alu_op        = word_s.alu_op;
  assign ctrl.cc_ld         = word_s.cc_ld;
  assign ctrl.halted        = word_s.halted;

endmodule
